filter_window_ctrl: RTL and testbench

- Sequencer for the 3x3 mean-average filter datapath.
- Accepts 3-pixel image columns from the upstream row buffer and shifts them into a 3x3 window.
- Drives the 216-bit window, the edge flag and the enable pulse into mean_average with the required settle timing. Waits for pixel_done, then presents each filtered pixel with its coordinates on a valid/ready output.
- Sits between the row buffer / edge detector and the output frame writer.

---
 rtl/filter_pkg.sv | 19 +
 rtl/window_shift_reg.sv | 48 ++++
 rtl/filter_window_ctrl.sv | 129 ++++++++++++
 tb/tb_filter_window_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_pkg.sv
// Shared types and constants for the 3x3 mean-average filter sequencer.
package filter_pkg;

  localparam int unsigned PIX_W = 24;
  localparam int unsigned COL_W = 72;
  localparam int unsigned WIN_W = 216;

  localparam logic [PIX_W-1:0] EDGE_PIXEL = 24'h141414;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    SETTLE,
    FIRE,
    WAIT,
    OUT
  } ctrl_state_t;

endpackage

// File: rtl/window_shift_reg.sv
// 3x3 pixel window built from three shifted columns plus the centre column's edge flag.
module window_shift_reg
  import filter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             shift,
  input  logic             clear,
  input  logic [COL_W-1:0] col_data,
  input  logic             col_edge,
  output logic [WIN_W-1:0] window,
  output logic             centre_edge
);

  logic [COL_W-1:0] col_l, col_c, col_r;
  logic             edge_c, edge_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_l  <= '0;
      col_c  <= '0;
      col_r  <= '0;
      edge_c <= 1'b0;
      edge_r <= 1'b0;
    end else if (clear) begin
      col_l  <= '0;
      col_c  <= '0;
      col_r  <= '0;
      edge_c <= 1'b0;
      edge_r <= 1'b0;
    end else if (shift) begin
      col_l  <= col_c;
      col_c  <= col_r;
      col_r  <= col_data;
      edge_c <= edge_r;
      edge_r <= col_edge;
    end
  end

  // Columns hold {top, mid, bottom}; the window is row-major, top-left first.
  always_comb begin
    window = {col_l[71:48], col_c[71:48], col_r[71:48],
              col_l[47:24], col_c[47:24], col_r[47:24],
              col_l[23:0],  col_c[23:0],  col_r[23:0]};
    centre_edge = edge_c;
  end

endmodule

// File: rtl/filter_window_ctrl.sv
// Sequences column fill, settle, enable strobe and result handoff for mean_average.
module filter_window_ctrl
  import filter_pkg::*;
#(
  parameter int unsigned IMG_W = 320,
  parameter int unsigned IMG_H = 240,
  parameter int unsigned XW    = $clog2(IMG_W),
  parameter int unsigned YW    = $clog2(IMG_H)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             col_valid,
  input  logic [COL_W-1:0] col_data,
  input  logic             col_edge,
  output logic             col_ready,
  output logic [WIN_W-1:0] ma_pixel_data,
  output logic             ma_is_edge,
  output logic             ma_enable,
  input  logic             ma_done,
  input  logic [PIX_W-1:0] ma_f_pixel,
  output logic             out_valid,
  output logic [PIX_W-1:0] out_pixel,
  output logic [XW-1:0]    out_x,
  output logic [YW-1:0]    out_y,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_done
);

  // x counts columns accepted in the row and must reach IMG_W, hence one extra bit of range.
  localparam int unsigned CW = $clog2(IMG_W + 1);

  ctrl_state_t   state, state_nx;
  logic [CW-1:0] x;
  logic [YW-1:0] y;
  logic          settle_cnt;
  logic          shift, clear, row_end, frame_end;

  assign row_end   = (x == CW'(IMG_W));
  assign frame_end = (y == YW'(IMG_H - 2));
  assign clear     = ((state == IDLE) && start) ||
                     ((state == OUT) && out_ready && row_end);

  window_shift_reg u_win (
    .clk        (clk),
    .rst        (rst),
    .shift      (shift),
    .clear      (clear),
    .col_data   (col_data),
    .col_edge   (col_edge),
    .window     (ma_pixel_data),
    .centre_edge(ma_is_edge)
  );

  always_comb begin
    state_nx  = state;
    col_ready = 1'b0;
    ma_enable = 1'b0;
    out_valid = 1'b0;
    shift     = 1'b0;
    unique case (state)
      IDLE:   if (start) state_nx = FILL;
      FILL: begin
        col_ready = 1'b1;
        if (col_valid) begin
          shift = 1'b1;
          if (x >= CW'(2)) state_nx = SETTLE;
        end
      end
      SETTLE: if (settle_cnt) state_nx = FIRE;
      FIRE: begin
        ma_enable = 1'b1;
        state_nx  = WAIT;
      end
      WAIT:   if (ma_done) state_nx = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = (row_end && frame_end) ? IDLE : FILL;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      settle_cnt <= 1'b0;
      out_pixel  <= '0;
      out_x      <= '0;
      out_y      <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      frame_done <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          x    <= '0;
          y    <= YW'(1);
          busy <= 1'b1;
        end
        FILL: if (col_valid) begin
          x          <= x + CW'(1);
          settle_cnt <= 1'b0;
        end
        SETTLE: settle_cnt <= 1'b1;
        WAIT: if (ma_done) begin
          out_pixel <= ma_f_pixel;
          out_x     <= XW'(x - CW'(2));
          out_y     <= y;
        end
        OUT: if (out_ready && row_end) begin
          x <= '0;
          if (frame_end) begin
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end else begin
            y <= y + YW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_filter_window_ctrl.sv
// Directed bench for filter_window_ctrl on a 5x4 image with a behavioural mean_average stub.
module tb_filter_window_ctrl;
  import filter_pkg::*;

  localparam int unsigned IMG_W = 5;
  localparam int unsigned IMG_H = 4;
  localparam int unsigned XW    = $clog2(IMG_W);
  localparam int unsigned YW    = $clog2(IMG_H);
  localparam int unsigned NCOL  = IMG_W * (IMG_H - 2);
  localparam int unsigned NPIX  = (IMG_W - 2) * (IMG_H - 2);

  typedef struct {
    logic [COL_W-1:0] col;
    logic             edge_f;
    logic             has_out;
    logic [XW-1:0]    ex;
    logic [YW-1:0]    ey;
    logic [PIX_W-1:0] epix;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start, col_valid, col_edge, out_ready;
  logic [COL_W-1:0] col_data;
  logic             col_ready, ma_is_edge, ma_enable, out_valid, busy, frame_done;
  logic [WIN_W-1:0] ma_pixel_data;
  logic             ma_done = 1'b0;
  logic [PIX_W-1:0] ma_f_pixel = '0;
  logic [PIX_W-1:0] out_pixel;
  logic [XW-1:0]    out_x;
  logic [YW-1:0]    out_y;

  filter_window_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk(clk), .rst(rst), .start(start), .col_valid(col_valid), .col_data(col_data),
    .col_edge(col_edge), .col_ready(col_ready), .ma_pixel_data(ma_pixel_data),
    .ma_is_edge(ma_is_edge), .ma_enable(ma_enable), .ma_done(ma_done),
    .ma_f_pixel(ma_f_pixel), .out_valid(out_valid), .out_pixel(out_pixel),
    .out_x(out_x), .out_y(out_y), .out_ready(out_ready), .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [PIX_W-1:0] avg9(input logic [WIN_W-1:0] w);
    int unsigned s;
    logic [PIX_W-1:0] r;
    r = '0;
    for (int ch = 0; ch < 3; ch++) begin
      s = 0;
      for (int p = 0; p < 9; p++) s += 32'(w[215-24*p-8*ch -: 8]);
      r[23-8*ch -: 8] = 8'(s / 9);
    end
    return r;
  endfunction

  // mean_average stand-in: one-cycle latency, edge pixels forced to EDGE_PIXEL.
  always @(posedge clk) begin
    ma_done <= 1'b0;
    if (ma_enable) begin
      ma_done    <= 1'b1;
      ma_f_pixel <= ma_is_edge ? EDGE_PIXEL : avg9(ma_pixel_data);
    end
  end

  int unsigned n_chk = 0, n_fail = 0;
  vec_t        tbl [3][NCOL];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [COL_W-1:0] col3(input logic [7:0] t, input logic [7:0] m,
                                            input logic [7:0] b);
    return {t, t, t, m, m, m, b, b, b};
  endfunction

  function automatic logic [WIN_W-1:0] model_win(input logic [COL_W-1:0] l,
                                                 input logic [COL_W-1:0] c,
                                                 input logic [COL_W-1:0] r);
    logic [COL_W-1:0] cols [3];
    logic [WIN_W-1:0] w;
    cols[0] = l; cols[1] = c; cols[2] = r;
    w = '0;
    for (int row = 0; row < 3; row++)
      for (int cc = 0; cc < 3; cc++)
        w[215-24*(row*3+cc) -: 24] = cols[cc][71-24*row -: 24];
    return w;
  endfunction

  // Monitor state: bench-side window model and recorded outputs.
  logic [COL_W-1:0] m_l, m_c, m_r;
  logic             e_c, e_r;
  int unsigned      m_cols, en_cnt, fd_cnt, out_n;
  logic [WIN_W-1:0] prev1, prev2;
  logic [XW-1:0]    got_x   [64];
  logic [YW-1:0]    got_y   [64];
  logic [PIX_W-1:0] got_pix [64];

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (rst) begin
        m_l = '0; m_c = '0; m_r = '0; e_c = 1'b0; e_r = 1'b0; m_cols = 0;
        prev1 = '0; prev2 = '0;
      end else begin
        if (ma_enable) begin
          en_cnt++;
          chk("en_window_stable", 256'(ma_pixel_data == prev1 && ma_pixel_data == prev2), 256'(1));
          chk("en_window_content", 256'(ma_pixel_data), 256'(model_win(m_l, m_c, m_r)));
          chk("en_centre_edge", 256'(ma_is_edge), 256'(e_c));
          chk("en_after_two_cols", 256'(m_cols >= 3), 256'(1));
          chk("en_col_ready_low", 256'(col_ready), 256'(0));
        end
        if (frame_done) fd_cnt++;
        if (out_valid && out_ready) begin
          if (out_n < 64) begin
            got_x[out_n] = out_x; got_y[out_n] = out_y; got_pix[out_n] = out_pixel;
          end
          out_n++;
          if (m_cols == IMG_W) begin
            m_l = '0; m_c = '0; m_r = '0; e_c = 1'b0; e_r = 1'b0; m_cols = 0;
          end
        end
        if (col_valid && col_ready) begin
          m_l = m_c; m_c = m_r; m_r = col_data;
          e_c = e_r; e_r = col_edge;
          m_cols++;
        end
        prev2 = prev1;
        prev1 = ma_pixel_data;
      end
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_col_ready"},  256'(col_ready),     256'(0));
    chk({tag, "_ma_enable"},  256'(ma_enable),     256'(0));
    chk({tag, "_out_valid"},  256'(out_valid),     256'(0));
    chk({tag, "_busy"},       256'(busy),          256'(0));
    chk({tag, "_frame_done"}, 256'(frame_done),    256'(0));
    chk({tag, "_out_data"},   256'({out_pixel, out_x, out_y}), 256'(0));
    chk({tag, "_window"},     256'({ma_pixel_data, ma_is_edge}), 256'(0));
  endtask

  // Called at posedge+1; returns at posedge+1 after the column is taken.
  task automatic feed_col(input logic [COL_W-1:0] d, input logic e, input bit gaps);
    int unsigned n;
    logic acc;
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        col_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    col_valid = 1'b1; col_data = d; col_edge = e;
    n = 0;
    do begin
      @(negedge clk);
      acc = col_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) chk("col_accept_timeout", 256'(0), 256'(1));
    col_valid = 1'b0;
  endtask

  task automatic stall_seq();
    int unsigned n;
    logic [PIX_W-1:0] p0;
    logic [XW-1:0]    x0;
    logic [YW-1:0]    y0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 100);
    chk("stall_first_valid", 256'(out_valid), 256'(1));
    p0 = out_pixel; x0 = out_x; y0 = out_y;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_hold", 256'({out_valid, out_pixel, out_x, out_y, col_ready, ma_enable}),
          256'({1'b1, p0, x0, y0, 1'b0, 1'b0}));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
  endtask

  task automatic run_frame(input int sel, input bit gaps, input bit stall, input string tag);
    int unsigned base_en, base_fd, base_out, n, j;
    base_en = en_cnt; base_fd = fd_cnt; base_out = out_n;
    out_ready = !stall;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy_after_start"}, 256'(busy), 256'(1));
    fork
      begin
        for (int i = 0; i < NCOL; i++) begin
          if (gaps && i == 4) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
          end
          feed_col(tbl[sel][i].col, tbl[sel][i].edge_f, gaps);
        end
      end
      begin
        if (stall) stall_seq();
      end
    join
    n = 0;
    while (fd_cnt == base_fd && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_frame_done_pulses"}, 256'(fd_cnt - base_fd), 256'(1));
    chk({tag, "_busy_end"},          256'(busy), 256'(0));
    chk({tag, "_enable_pulses"},     256'(en_cnt - base_en), 256'(NPIX));
    chk({tag, "_output_count"},      256'(out_n - base_out), 256'(NPIX));
    j = base_out;
    for (int i = 0; i < NCOL; i++) begin
      if (tbl[sel][i].has_out) begin
        if (j < out_n && j < 64) begin
          chk({tag, "_out_x"},     256'(got_x[j]),   256'(tbl[sel][i].ex));
          chk({tag, "_out_y"},     256'(got_y[j]),   256'(tbl[sel][i].ey));
          chk({tag, "_out_pixel"}, 256'(got_pix[j]), 256'(tbl[sel][i].epix));
        end
        j++;
      end
    end
  endtask

  initial begin
    logic [7:0]       gt [5], gm [5], gb [5];
    logic [PIX_W-1:0] gp [5];
    int unsigned      idx;

    // Distinct-column row: centre averages floor((sum of nine)/9) per channel.
    gt = '{8'd10, 8'd40, 8'd70, 8'd9, 8'd90};
    gm = '{8'd20, 8'd50, 8'd80, 8'd9, 8'd90};
    gb = '{8'd30, 8'd60, 8'd90, 8'd9, 8'd90};
    gp = '{24'h0, 24'h0, 24'h323232, 24'h2E2E2E, 24'h3B3B3B};
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 5; k++) begin
        idx = r * 5 + k;
        tbl[0][idx] = '{col: col3(8'h80, 8'h80, 8'h80), edge_f: 1'b0, has_out: (k >= 2),
                        ex: XW'(k - 1), ey: YW'(r + 1), epix: 24'h808080};
        tbl[1][idx] = tbl[0][idx];
        tbl[1][idx].edge_f = (r == 0 && k == 2);
        if (r == 0 && k == 3) tbl[1][idx].epix = 24'h141414;
        tbl[2][idx] = '{col: col3(gt[k], gm[k], gb[k]), edge_f: 1'b0, has_out: (k >= 2),
                        ex: XW'(k - 1), ey: YW'(r + 1), epix: gp[k]};
      end
    end

    start = 1'b0; col_valid = 1'b0; col_data = '0; col_edge = 1'b0; out_ready = 1'b1;
    en_cnt = 0; fd_cnt = 0; out_n = 0; m_cols = 0;
    fork
      monitor_loop();
    join_none

    #1 rst = 1'b1;
    #1 check_reset("por");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Abort a frame part-way, then confirm a clean frame follows.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) feed_col(tbl[0][i].col, 1'b0, 1'b0);
    chk("pre_reset_busy", 256'(busy), 256'(1));
    #2 rst = 1'b1;
    #1 check_reset("mid_reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_frame(0, 1'b0, 1'b0, "uniform");
    run_frame(1, 1'b0, 1'b0, "edge");
    run_frame(0, 1'b0, 1'b1, "stall");
    run_frame(2, 1'b1, 1'b0, "gaps");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, %0d checks so far", n_chk);
    $fatal(1, "timeout");
  end

endmodule
